// File: rtl/pico_uart_tx_if.sv
// PicoRV32 native-bus slave port bundle for the UART transmitter.
interface pico_uart_tx_if;
    logic        io_valid;
    logic [1:0]  rv_adr;
    logic [3:0]  rv_wstrb;
    logic [31:0] rv_wdata;
    logic [31:0] rv_rdata;
    logic        io_ready;

    modport master (
        output io_valid, rv_adr, rv_wstrb, rv_wdata,
        input  rv_rdata, io_ready
    );

    modport slave (
        input  io_valid, rv_adr, rv_wstrb, rv_wdata,
        output rv_rdata, io_ready
    );
endinterface

// File: rtl/pico_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO on the PicoRV32 native bus.
module pico_uart_tx #(
    parameter logic [15:0] DIVISOR_RST = 16'd35,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic          clk,
    input  logic          resetn,
    pico_uart_tx_if.slave bus,
    output logic          uart_txd,
    output logic          irq_empty
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e             state_q, state_d;
    logic [15:0]        div_q;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               txd_d;
    logic               ovf_q;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;

    logic        acc_c, wr_c, rd_c, push_c, push_ok_c, pop_c;
    logic        empty_c, full_c, bit_end_c;
    logic [31:0] rdata_c;
    logic        unused_c;

    // Transaction strobes: accept once per request, on the cycle io_ready rises
    assign acc_c     = bus.io_valid & ~bus.io_ready;
    assign wr_c      = acc_c & bus.rv_wstrb[0];
    assign rd_c      = acc_c & (bus.rv_wstrb == 4'b0000);
    assign push_c    = wr_c & (bus.rv_adr == 2'd0);
    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CW'(DEPTH));
    assign push_ok_c = push_c & (~full_c | pop_c);
    assign count_d   = count_q + CW'(push_ok_c) - CW'(pop_c);
    assign bit_end_c = (baud_q == 16'd0);
    assign unused_c  = ^bus.rv_wdata[31:16];

    // Register read mux
    always_comb begin
        rdata_c = '0;
        case (bus.rv_adr)
            2'd1:    rdata_c = {16'd0, 8'(count_q), 4'd0, ovf_q, empty_c, full_c, (state_q != IDLE)};
            2'd2:    rdata_c = {16'd0, div_q};
            default: rdata_c = '0;
        endcase
    end

    // Bus handshake, read data and control registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.io_ready <= 1'b0;
            bus.rv_rdata <= '0;
            div_q        <= DIVISOR_RST;
            ovf_q        <= 1'b0;
        end else begin
            bus.io_ready <= acc_c;
            bus.rv_rdata <= rd_c ? rdata_c : '0;
            if (wr_c && (bus.rv_adr == 2'd2)) begin
                div_q <= (bus.rv_wdata[15:0] == 16'd0) ? 16'd1 : bus.rv_wdata[15:0];
            end
            if (wr_c && (bus.rv_adr == 2'd1)) begin
                ovf_q <= 1'b0;
            end else if (push_c && full_c && !pop_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr_q] <= bus.rv_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + FIFO_AW'(push_ok_c);
            rd_ptr_q <= rd_ptr_q + FIFO_AW'(pop_c);
            count_q  <= count_d;
        end
    end

    // Serialiser next state: divisor is re-sampled at every bit boundary
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        pop_c    = 1'b0;
        txd_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                    baud_d  = div_q - 16'd1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    baud_d   = div_q - 16'd1;
                    bitcnt_d = 3'd0;
                    state_d  = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    baud_d = div_q - 16'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        shreg_d  = {1'b0, shreg_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shreg_d = mem[rd_ptr_q];
                        baud_d  = div_q - 16'd1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Serialiser state and registered line/interrupt outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            uart_txd  <= 1'b1;
            irq_empty <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            uart_txd  <= txd_d;
            irq_empty <= (count_d == '0) && (state_d == IDLE);
        end
    end
endmodule

// File: tb/tb_pico_uart_tx.sv
// Self-checking bench for pico_uart_tx: frame-level line model plus directed cases.
module tb_pico_uart_tx;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic uart_txd;
    logic irq_empty;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    pico_uart_tx_if bus();

    pico_uart_tx #(.DIVISOR_RST(16'd35), .FIFO_AW(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus.slave),
        .uart_txd  (uart_txd),
        .irq_empty (irq_empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Line model: bytes waiting, current frame as 10 bits, elapsed cycles in frame
    logic [7:0]  mq [$];
    int          m_div = 35;
    int          m_fdiv = 1;
    int          m_t = 0;
    bit          m_active = 1'b0;
    bit          m_ovf = 1'b0;
    logic [9:0]  m_frame = '1;
    bit          m_pv = 1'b0;
    bit          m_pr = 1'b0;
    logic [1:0]  m_pa = '0;
    logic [3:0]  m_pw = '0;
    logic [31:0] m_pd = '0;
    logic [31:0] m_stat = 32'h4;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        bit          exp_rdy;
        bit          was_act;
        bit          exp_txd;
        logic [31:0] exp_rd;
        if (!resetn) begin
            mq.delete();
            m_div = 35; m_active = 1'b0; m_ovf = 1'b0;
            m_pv = 1'b0; m_pr = 1'b0; m_stat = 32'h4;
            chk("rst_txd", 32'(uart_txd), 32'd1);
            chk("rst_irq", 32'(irq_empty), 32'd1);
            chk("rst_ready", 32'(bus.io_ready), 32'd0);
        end else begin
            exp_rdy = m_pv && !m_pr;
            if (!m_active && mq.size() > 0) begin
                m_frame  = {1'b1, mq.pop_front(), 1'b0};
                m_fdiv   = m_div;
                m_t      = 0;
                m_active = 1'b1;
            end
            was_act = m_active;
            exp_txd = m_active ? m_frame[m_t / m_fdiv] : 1'b1;
            if (m_active) begin
                m_t++;
                if (m_t == 10 * m_fdiv) m_active = 1'b0;
            end
            if (exp_rdy) begin
                if (m_pw == 4'b0000) begin
                    exp_rd = (m_pa == 2'd1) ? m_stat :
                             (m_pa == 2'd2) ? 32'(m_div) : 32'd0;
                    chk("rdata", bus.rv_rdata, exp_rd);
                end else if (m_pw[0]) begin
                    case (m_pa)
                        2'd0: if (mq.size() < DEPTH) mq.push_back(m_pd[7:0]); else m_ovf = 1'b1;
                        2'd1: m_ovf = 1'b0;
                        2'd2: m_div = (m_pd[15:0] == 16'd0) ? 1 : int'(m_pd[15:0]);
                        default: ;
                    endcase
                end
            end
            chk("io_ready", 32'(bus.io_ready), 32'(exp_rdy));
            chk("uart_txd", 32'(uart_txd), 32'(exp_txd));
            chk("irq_empty", 32'(irq_empty), 32'(mq.size() == 0 && !was_act));
            m_stat = {16'd0, 8'(mq.size()), 4'd0, m_ovf, mq.size() == 0, mq.size() == DEPTH, was_act};
            m_pv = bus.io_valid; m_pr = exp_rdy;
            m_pa = bus.rv_adr; m_pw = bus.rv_wstrb; m_pd = bus.rv_wdata;
        end
    end

    // One bus transfer; called and returns just after a rising edge
    task automatic xfer(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output int at);
        bus.io_valid = 1'b1; bus.rv_adr = a; bus.rv_wstrb = s; bus.rv_wdata = d;
        rd = '0; at = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.io_ready) begin
                rd = bus.rv_rdata; at = cyc;
                break;
            end
        end
        if (at < 0) chk("bus_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.io_valid = 1'b0; bus.rv_wstrb = 4'b0000;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, output int at);
        logic [31:0] rd;
        xfer(a, 4'b0001, d, rd, at);
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [31:0] rd);
        int at;
        xfer(a, 4'b0000, 32'd0, rd, at);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_irq(input int from, input int lim, input int exp_dt, input string nm);
        int dt;
        dt = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (irq_empty) begin
                dt = cyc - from;
                break;
            end
        end
        chk(nm, 32'(dt), 32'(exp_dt));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          p, p2, at;
        logic [39:0] samp;
        logic [9:0]  bits;
        logic [5:0]  pat;

        bus.io_valid = 1'b0; bus.rv_adr = '0; bus.rv_wstrb = '0; bus.rv_wdata = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_txd", 32'(uart_txd), 32'd1);
        chk("reset_irq", 32'(irq_empty), 32'd1);
        chk("reset_rdata", bus.rv_rdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        rdreg(2'd1, rd); chk("reset_stat", rd, 32'h0000_0004);
        rdreg(2'd2, rd); chk("reset_div", rd, 32'd35);

        // Register map corners
        wr(2'd2, 32'd0, at);
        rdreg(2'd2, rd); chk("div_zero_as_one", rd, 32'd1);
        wr(2'd2, 32'd4, at);
        rdreg(2'd3, rd); chk("reg3_read", rd, 32'd0);
        rdreg(2'd0, rd); chk("data_read", rd, 32'd0);
        xfer(2'd0, 4'b0010, 32'h0000_00EE, rd, at);
        rdreg(2'd1, rd); chk("nostrobe_stat", rd, 32'h0000_0004);

        // Single byte 0x55 at DIV=4
        wr(2'd0, 32'h55, p);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            samp[i] = uart_txd;
        end
        for (int k = 0; k < 10; k++) bits[k] = samp[k * 4 + 1];
        chk("frame_55", 32'(bits), 32'h0000_02AA);
        wait_irq(p, 10, 41, "irq_after_single");

        // Burst of three at DIV=2
        wr(2'd2, 32'd2, at);
        wr(2'd0, 32'h00, p);
        wr(2'd0, 32'hFF, at);
        wr(2'd0, 32'hA5, at);
        rdreg(2'd1, rd); chk("burst_count0", 32'(rd[15:8]), 32'd2);
        wait_until(p + 21);
        rdreg(2'd1, rd); chk("burst_count1", 32'(rd[15:8]), 32'd1);
        wait_until(p + 41);
        rdreg(2'd1, rd); chk("burst_count2", 32'(rd[15:8]), 32'd0);
        wait_irq(p, 100, 61, "irq_after_burst");

        // Overflow at DIV=100
        wr(2'd2, 32'd100, at);
        wr(2'd0, 32'h03, p);
        for (int i = 1; i < DEPTH + 2; i++) wr(2'd0, 32'(i * 7 + 3), at);
        rdreg(2'd1, rd); chk("ovf_stat", rd, 32'h0000_100B);
        wr(2'd1, 32'd0, at);
        rdreg(2'd1, rd); chk("ovf_cleared", rd, 32'h0000_1003);
        wait_irq(p, 20000, 17001, "irq_after_overflow");

        // Held request: two pulses, two pushes
        wr(2'd2, 32'd3, at);
        bus.io_valid = 1'b1; bus.rv_adr = 2'd0; bus.rv_wstrb = 4'b0001; bus.rv_wdata = 32'h3C;
        p = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = bus.io_ready;
            if (bus.io_ready && p < 0) p = cyc;
            if (i == 3) begin
                @(posedge clk); #1;
                bus.io_valid = 1'b0; bus.rv_wstrb = 4'b0000;
            end
        end
        chk("hold_ready_pattern", 32'(pat), 32'h0000_000A);
        wait_irq(p, 100, 61, "irq_after_hold");

        // Reset during data bit 3
        wr(2'd2, 32'd4, at);
        wr(2'd0, 32'hC3, p);
        wait_until(p + 18);
        resetn = 1'b0;
        #1;
        chk("txd_async_reset", 32'(uart_txd), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        rdreg(2'd1, rd); chk("post_reset_stat", rd, 32'h0000_0004);
        rdreg(2'd2, rd); chk("post_reset_div", rd, 32'd35);
        wr(2'd0, 32'h81, p2);
        wait_irq(p2, 400, 351, "irq_after_clean_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
